fifo_word_packer: RTL and testbench

Read-side consumer of the asynchronous FIFO. It runs in the FIFO read-clock domain, pops bytes through the FIFO read port without ever underflowing it, and packs `LANES` consecutive bytes into one wide word. Words are presented on a valid/ready output interface. A flush request emits a partial word with a byte-enable mask.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/word_out_slot.sv | 54 +++++
 rtl/fifo_word_packer.sv | 133 +++++++++++++
 tb/tb_fifo_word_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the FIFO read-side word packer.
//                Holds the packer FSM state type, default lane geometry and
//                the byte-enable mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LANES = 4;

  // Upper bound on lane count the mask helper can express.
  localparam int MAX_LANES = 32;

  // Returns a mask with the low `cnt` bits set; callers truncate to LANES.
  function automatic logic [MAX_LANES-1:0] be_mask(input int unsigned cnt);
    logic [MAX_LANES:0] one_hot;
    one_hot = (MAX_LANES + 1)'(1) << cnt;
    be_mask = MAX_LANES'(one_hot - 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : word_out_slot
//  Description : Single-entry valid/ready output register with a load port
//                and a wrapping count of accepted words.
//  Ports       : clk_i, res_n_i      - clock, async active-low reset
//                load, load_data,
//                load_be             - write a new word (only when free or
//                                      being accepted this cycle)
//                ready               - downstream ready
//                valid, data, be     - output word
//                words               - accepted-word counter
//  Revision    : 1.0 - initial release
// ============================================================================
module word_out_slot #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   res_n_i,
  input  logic                   load,
  input  logic [WIDTH*LANES-1:0] load_data,
  input  logic [LANES-1:0]       load_be,
  input  logic                   ready,
  output logic                   valid,
  output logic [WIDTH*LANES-1:0] data,
  output logic [LANES-1:0]       be,
  output logic [CNT_W-1:0]       words
);

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      valid <= 1'b0;
      data  <= '0;
      be    <= '0;
      words <= '0;
    end else begin
      // A load may coincide with the acceptance of the previous word.
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
        be    <= load_be;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (valid && ready) begin
        words <= words + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_word_packer
//  Description : Read-side consumer of an asynchronous FIFO. Pops bytes
//                without underflow, packs LANES bytes into one word and
//                presents it on a valid/ready interface. A flush emits the
//                partially filled word with a byte-enable mask.
//  Ports       : clk_i, res_n_i        - read clock, async active-low reset
//                fifo_empty_i          - FIFO empty flag
//                fifo_rd_en_o          - FIFO pop request (combinational)
//                fifo_rdata_i          - FIFO data, valid one cycle after pop
//                flush_i               - request to emit the partial word
//                word_valid_o/ready_i  - output handshake
//                word_data_o, word_be_o- packed word, lane 0 = first byte
//                words_o               - accepted-word counter
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = DEFAULT_LANES,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   res_n_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_en_o,
  input  logic [WIDTH-1:0]       fifo_rdata_i,
  input  logic                   flush_i,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic [WIDTH*LANES-1:0] word_data_o,
  output logic [LANES-1:0]       word_be_o,
  output logic [CNT_W-1:0]       words_o
);

  localparam int IDX_W    = $clog2(LANES);
  localparam int CNT_BITS = IDX_W + 1;
  localparam logic [CNT_BITS-1:0] LANES_C = CNT_BITS'(LANES);

  state_t              state;
  logic [WIDTH-1:0]    acc [LANES];
  logic [CNT_BITS-1:0] acc_cnt;
  logic                inflight;

  logic [CNT_BITS-1:0]    cnt_after;
  logic                   slot_free;
  logic                   full_move;
  logic                   partial_load;
  logic                   load;
  logic [WIDTH*LANES-1:0] load_data;
  logic [LANES-1:0]       load_be;

  // Byte count once the in-flight byte (if any) has landed this edge.
  assign cnt_after = acc_cnt + {{(CNT_BITS-1){1'b0}}, inflight};

  // Counting the in-flight byte keeps the accumulator from ever overfilling.
  assign fifo_rd_en_o = (state == RUN) && !fifo_empty_i && (cnt_after < LANES_C);

  assign slot_free    = !word_valid_o || word_ready_i;
  assign full_move    = (cnt_after == LANES_C) && slot_free;
  assign partial_load = (state == FLUSH_WAIT) && !inflight && (acc_cnt != '0) && slot_free;
  assign load         = full_move || partial_load;

  // Word as it will look after this edge's landing; unfilled lanes read zero.
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] lane;
      assign lane = (inflight && (acc_cnt == CNT_BITS'(i))) ? fifo_rdata_i : acc[i];
      assign load_data[i*WIDTH +: WIDTH] = (CNT_BITS'(i) < cnt_after) ? lane : '0;
    end
  endgenerate

  assign load_be = LANES'(be_mask(32'(cnt_after)));

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state    <= RUN;
      acc_cnt  <= '0;
      inflight <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
    end else begin
      inflight <= fifo_rd_en_o;

      if (inflight) begin
        acc[acc_cnt[IDX_W-1:0]] <= fifo_rdata_i;
      end

      if (load) begin
        acc_cnt <= '0;
      end else begin
        acc_cnt <= cnt_after;
      end

      case (state)
        RUN: begin
          // A flush whose last byte completes a word this edge needs no partial.
          if (flush_i && (cnt_after != '0) && !full_move) begin
            state <= FLUSH_WAIT;
          end
        end
        FLUSH_WAIT: begin
          if (load || (!inflight && (acc_cnt == '0))) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  word_out_slot #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_slot (
    .clk_i     (clk_i),
    .res_n_i   (res_n_i),
    .load      (load),
    .load_data (load_data),
    .load_be   (load_be),
    .ready     (word_ready_i),
    .valid     (word_valid_o),
    .data      (word_data_o),
    .be        (word_be_o),
    .words     (words_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_word_packer
//  Description : Self-checking bench for fifo_word_packer. A queue models the
//                FIFO; popped bytes are grouped into expected words in pop
//                order, flushes close a partial group.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int CNT_W = 16;
  localparam int WW    = WIDTH * LANES;

  logic             clk   = 1'b0;
  logic             res_n = 1'b0;
  logic             empty = 1'b1;
  logic             rd_en;
  logic [WIDTH-1:0] rdata = '0;
  logic             flush = 1'b0;
  logic             valid;
  logic             ready = 1'b0;
  logic [WW-1:0]    data;
  logic [LANES-1:0] be;
  logic [CNT_W-1:0] words;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i        (clk),
    .res_n_i      (res_n),
    .fifo_empty_i (empty),
    .fifo_rd_en_o (rd_en),
    .fifo_rdata_i (rdata),
    .flush_i      (flush),
    .word_valid_o (valid),
    .word_ready_i (ready),
    .word_data_o  (data),
    .word_be_o    (be),
    .words_o      (words)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fifo_q [$];
  logic [WIDTH-1:0] pend [$];
  logic [WW-1:0]    exp_data [$];
  logic [LANES-1:0] exp_be [$];
  int               xfer_cyc [$];
  int               pops  = 0;
  int               xfers = 0;
  int               cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Close the current group of popped bytes into an expected word.
  function automatic void model_emit();
    logic [WW-1:0]    w;
    logic [LANES-1:0] m;
    w = '0;
    m = '0;
    for (int i = 0; i < pend.size(); i++) begin
      w[i*WIDTH +: WIDTH] = pend[i];
      m[i] = 1'b1;
    end
    exp_data.push_back(w);
    exp_be.push_back(m);
    pend.delete();
  endfunction

  function automatic void model_byte(input logic [WIDTH-1:0] b);
    pend.push_back(b);
    if (pend.size() == LANES) model_emit();
  endfunction

  function automatic void model_flush();
    if (pend.size() != 0) model_emit();
  endfunction

  task automatic push(input logic [WIDTH-1:0] b);
    fifo_q.push_back(b);
  endtask

  // One clock: capture what the DUT sees at the edge, then apply the FIFO pop
  // and score any transfer.
  task automatic cycle();
    logic             p_rd, p_v, p_r;
    logic [WW-1:0]    p_d;
    logic [LANES-1:0] p_be;
    logic [WIDTH-1:0] b;
    empty = (fifo_q.size() == 0);
    #1;
    p_rd = rd_en;
    p_v  = valid;
    p_r  = ready;
    p_d  = data;
    p_be = be;
    if (empty) check("pop_while_empty", 64'(rd_en), 64'(0));
    @(posedge clk);
    #1;
    cyc++;
    if (p_rd) begin
      if (fifo_q.size() == 0) begin
        check("pop_underflow", 64'(1), 64'(0));
      end else begin
        b = fifo_q.pop_front();
        rdata = b;
        pops++;
        model_byte(b);
      end
    end
    if (p_v && p_r) begin
      if (exp_data.size() == 0) begin
        check("spurious_word", 64'(p_d), 64'(0));
        errors += (p_d === '0) ? 1 : 0;
      end else begin
        check("word_data", 64'(p_d), 64'(exp_data.pop_front()));
        check("word_be", 64'(p_be), 64'(exp_be.pop_front()));
      end
      xfers++;
      xfer_cyc.push_back(cyc);
      check("words_cnt", 64'(words), 64'(xfers % (1 << CNT_W)));
    end else if (p_v) begin
      check("hold_valid", 64'(valid), 64'(1));
      check("hold_data", 64'(data), 64'(p_d));
      check("hold_be", 64'(be), 64'(p_be));
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int p0;
    int guard;

    // Reset values
    repeat (3) @(posedge clk);
    #3;
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_data", 64'(data), 64'(0));
    check("rst_be", 64'(be), 64'(0));
    check("rst_words", 64'(words), 64'(0));
    check("rst_rd_en", 64'(rd_en), 64'(0));
    res_n = 1'b1;

    // Single full word
    ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run(10);
    check("t1_words", 64'(words), 64'(1));
    check("t1_drained", 64'(exp_data.size()), 64'(0));

    // Two back-to-back words, spacing reflects the one-cycle bubble
    xfer_cyc.delete();
    for (int i = 1; i <= 8; i++) push(WIDTH'(i));
    run(16);
    check("t2_count", 64'(xfer_cyc.size()), 64'(2));
    if (xfer_cyc.size() >= 2) check("t2_spacing", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'(5));
    check("t2_words", 64'(words), 64'(3));

    // Partial word via flush, then an idle flush that must emit nothing
    push(8'hA1); push(8'hA2); push(8'hA3);
    run(8);
    p0 = xfers;
    model_flush();
    flush = 1'b1; cycle(); flush = 1'b0;
    run(6);
    check("t3_partial", 64'(xfers - p0), 64'(1));
    flush = 1'b1; cycle(); flush = 1'b0;
    run(6);
    check("t3_idle_flush", 64'(xfers - p0), 64'(1));

    // Back-pressure: only two words' worth of bytes may be popped
    ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 12; i++) push(WIDTH'(8'hB0 + i));
    run(20);
    check("t4_pops", 64'(pops - p0), 64'(8));
    check("t4_left", 64'(fifo_q.size()), 64'(4));
    ready = 1'b1;
    run(20);
    check("t4_drained", 64'(exp_data.size()), 64'(0));

    // Flush while the last byte of a word is in flight
    p0 = pops;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    guard = 0;
    while ((pops - p0) < 4 && guard < 20) begin
      cycle();
      guard++;
    end
    check("t5_timeout", 64'(guard < 20), 64'(1));
    p0 = xfers;
    model_flush();
    flush = 1'b1; cycle(); flush = 1'b0;
    run(10);
    check("t5_one_word", 64'(xfers - p0), 64'(1));

    // Asynchronous reset with two bytes accumulated
    push(8'hE1); push(8'hE2);
    run(6);
    res_n = 1'b0;
    #1;
    check("t6_valid", 64'(valid), 64'(0));
    check("t6_data", 64'(data), 64'(0));
    check("t6_be", 64'(be), 64'(0));
    check("t6_words", 64'(words), 64'(0));
    check("t6_rd_en", 64'(rd_en), 64'(0));
    pend.delete();
    exp_data.delete();
    exp_be.delete();
    xfers = 0;
    @(posedge clk);
    #3;
    res_n = 1'b1;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    run(10);
    check("t6_words_after", 64'(words), 64'(1));

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) push(WIDTH'($urandom_range(0, 255)));
      cycle();
    end
    ready = 1'b1;
    run(30);
    model_flush();
    flush = 1'b1; cycle(); flush = 1'b0;
    run(10);
    check("rand_drained", 64'(exp_data.size()), 64'(0));
    check("rand_fifo_empty", 64'(fifo_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
